// File: rtl/fetch_prefetch_queue_if.sv
// Instruction-memory handshake between the fetch stage (master) and memory (slave).
// Requests use valid/ready; responses return in request order and are always accepted.
interface fetch_prefetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// IF stage: sequential fetch requests, in-order prefetch FIFO and IF/ID register,
// with redirect handling that discards stale in-flight responses.
module fetch_prefetch_queue #(
  parameter int XLEN     = 32,
  parameter int RESET_PC = 0,
  parameter int QDEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pcselE,
  input  logic [XLEN-1:0]        pcTargetE,
  input  logic                   stallD,
  input  logic                   flushD,
  fetch_prefetch_queue_if.master imem,
  output logic [31:0]            instrD,
  output logic [XLEN-1:0]        pcD,
  output logic [XLEN-1:0]        pc4D,
  output logic                   validD
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   QD_W = (CW+1)'(QDEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [31:0]     qinstr_q [QDEPTH];
  logic [XLEN-1:0] qpc_q    [QDEPTH];

  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [31:0]     instr_id_q, instr_id_d;
  logic [XLEN-1:0] pc_id_q, pc_id_d, pc4_id_q, pc4_id_d;
  logic            valid_id_q, valid_id_d;

  logic [CW:0]     credit_sum;
  logic            req_valid, fire, rsp, push, pop;

  // Credit counts both outstanding requests and buffered entries so a response
  // always finds a free slot.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, count_q};
  assign req_valid  = !rst && (credit_sum < QD_W);
  assign fire       = req_valid && imem.imem_req_ready;
  assign rsp        = imem.imem_rsp_valid;
  assign push       = rsp && (drop_q == '0);
  assign pop        = !stallD && !flushD && (count_q != '0);

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = fetch_pc_q;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    drop_d      = drop_q;
    instr_id_d  = instr_id_q;
    pc_id_d     = pc_id_q;
    pc4_id_d    = pc4_id_q;
    valid_id_d  = valid_id_q;
    inflight_d  = inflight_q + CW'(fire) - CW'(rsp);
    count_d     = count_q + CW'(push) - CW'(pop);

    if (fire) fetch_pc_d = fetch_pc_q + PC_STEP;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rsp_pc_d = rsp_pc_q + PC_STEP;
    end
    if (rsp && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (stallD) begin
      valid_id_d = valid_id_q;
    end else if (flushD || (count_q == '0)) begin
      instr_id_d = '0;
      pc_id_d    = '0;
      pc4_id_d   = '0;
      valid_id_d = 1'b0;
    end else begin
      instr_id_d = qinstr_q[rd_ptr_q];
      pc_id_d    = qpc_q[rd_ptr_q];
      pc4_id_d   = qpc_q[rd_ptr_q] + PC_STEP;
      valid_id_d = 1'b1;
    end

    // Everything still outstanding after this edge belongs to the old path.
    if (pcselE) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = pcTargetE;
      rsp_pc_d   = pcTargetE;
      drop_d     = inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qinstr_q[wr_ptr_q] <= imem.imem_rsp_data;
      qpc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      fetch_pc_q <= XLEN'(RESET_PC);
      rsp_pc_q   <= XLEN'(RESET_PC);
      instr_id_q <= '0;
      pc_id_q    <= '0;
      pc4_id_q   <= '0;
      valid_id_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      instr_id_q <= instr_id_d;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  assign instrD = instr_id_q;
  assign pcD    = pc_id_q;
  assign pc4D   = pc4_id_q;
  assign validD = valid_id_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed phases then randomized traffic, checked
// against a queue-based model of the fetch stage and an in-order latency memory.
module tb_fetch_prefetch_queue;
  localparam int XLEN     = 32;
  localparam int QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic            clk = 1'b0;
  logic            rst, pcselE, stallD, flushD;
  logic [XLEN-1:0] pcTargetE;
  logic [31:0]     instrD;
  logic [XLEN-1:0] pcD, pc4D;
  logic            validD;

  fetch_prefetch_queue_if #(.XLEN(XLEN)) imem ();

  fetch_prefetch_queue #(.XLEN(XLEN), .RESET_PC(0), .QDEPTH(QDEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pcselE    (pcselE),
    .pcTargetE (pcTargetE),
    .stallD    (stallD),
    .flushD    (flushD),
    .imem      (imem),
    .instrD    (instrD),
    .pcD       (pcD),
    .pc4D      (pc4D),
    .validD    (validD)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory: in-order pending requests, each with the cycle it may respond.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t pend[$];
  int   last_due = 0;
  int   cyc = 0;
  bit   g_rand_ready = 0;
  int   g_lat_min = 1;
  int   g_lat_max = 1;

  // Fetch-stage model.
  logic [31:0] m_q[$];
  int          m_inflight = 0;
  int          m_drop = 0;
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_rsp_pc = RESET_PC;
  logic [31:0] m_instrD = '0, m_pcD = '0, m_pc4D = '0;
  logic        m_validD = 1'b0;

  task automatic step(input logic r, input logic s, input logic f, input logic p,
                      input logic [31:0] t);
    logic exp_rv, fire, rsp;
    int   d;
    @(negedge clk);
    check("validD", validD, m_validD);
    check("pcD", pcD, m_pcD);
    check("pc4D", pc4D, m_pc4D);
    check("instrD", instrD, m_instrD);

    rst = r; stallD = s; flushD = f; pcselE = p; pcTargetE = t;
    imem.imem_req_ready = g_rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    rsp = 1'b0;
    imem.imem_rsp_data = $urandom;
    if (r) begin
      pend.delete();
      last_due = cyc;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp = 1'b1;
      imem.imem_rsp_data = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    imem.imem_rsp_valid = rsp;
    #1;
    exp_rv = !r && ((m_inflight + m_q.size()) < QDEPTH);
    check("req_valid", imem.imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem.imem_req_addr, m_fetch_pc);
    fire = exp_rv && imem.imem_req_ready;
    if (fire) begin
      d = cyc + $urandom_range(g_lat_min, g_lat_max);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{addr: m_fetch_pc, due: d});
    end

    if (r) begin
      m_q.delete();
      m_inflight = 0; m_drop = 0;
      m_fetch_pc = RESET_PC; m_rsp_pc = RESET_PC;
      m_instrD = '0; m_pcD = '0; m_pc4D = '0; m_validD = 1'b0;
    end else begin
      if (!s) begin
        if (!f && m_q.size() > 0) begin
          m_pcD = m_q.pop_front();
          m_pc4D = m_pcD + 32'd4;
          m_instrD = mem_word(m_pcD);
          m_validD = 1'b1;
        end else begin
          m_instrD = '0; m_pcD = '0; m_pc4D = '0; m_validD = 1'b0;
        end
      end
      if (rsp) begin
        m_inflight--;
        if (m_drop > 0) m_drop--;
        else begin
          m_q.push_back(m_rsp_pc);
          m_rsp_pc += 32'd4;
        end
      end
      if (fire) begin
        m_inflight++;
        m_fetch_pc += 32'd4;
      end
      if (p) begin
        m_q.delete();
        m_drop = m_inflight;
        m_fetch_pc = t;
        m_rsp_pc = t;
      end
    end
    cyc++;
  endtask

  initial begin
    logic r, s, f, p;
    logic [31:0] t;
    rst = 1'b1; stallD = 1'b0; flushD = 1'b0; pcselE = 1'b0; pcTargetE = '0;
    imem.imem_req_ready = 1'b1; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;
    repeat (2) @(posedge clk);

    // Reset, then straight-line fetch with a 1-cycle memory.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0);

    // Decode stall fills the queue and throttles requests.
    repeat (8) step(0, 1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);

    // 3-cycle memory with a redirect while requests are outstanding.
    g_lat_min = 3; g_lat_max = 3;
    repeat (6) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h100);
    repeat (12) step(0, 0, 0, 0, 0);

    // Flush alone, then flush under stall.
    g_lat_min = 1; g_lat_max = 1;
    repeat (4) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);

    // Reset in the middle of traffic.
    g_lat_min = 2; g_lat_max = 2;
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);

    // Randomized traffic.
    g_rand_ready = 1; g_lat_min = 1; g_lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 4) == 0);
      p = ($urandom_range(0, 19) == 0);
      f = p ? 1'b1 : ($urandom_range(0, 9) == 0);
      t = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step(r, s, f, p, t);
    end
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
